// File: rtl/video_timing_detector.sv
// rtl/video_timing_detector.sv - hs/vs/de timing analyser with lock detection and pixel coordinates
// Geometry is reported in generator units: totals are length minus 1, sync/active are plain counts.
module video_timing_detector #(
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 3,
  parameter int UNLOCK_FRAMES   = 2,
  parameter int TIMEOUT         = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hdmi_hs,
  input  logic        hdmi_vs,
  input  logic        hdmi_de,
  output logic        locked,
  output logic        frame_start,
  output logic        fmt_change,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_h_sync,
  output logic [11:0] meas_h_active,
  output logic [11:0] meas_v_total,
  output logic [11:0] meas_v_sync,
  output logic [11:0] meas_v_active,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y
);
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic          POL     = (SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_active;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_active;
  } geom_t;

  // Returns {saturated, next}; holds at 4095 and flags the attempt to go past it.
  function automatic logic [12:0] sat_inc(input logic [11:0] v, input logic en);
    if (!en) return {1'b0, v};
    if (v == 12'hFFF) return {1'b1, v};
    return {1'b0, v + 12'd1};
  endfunction

  logic hs_s1_q, vs_s1_q, de_s1_q, hs_s2_q, vs_s2_q;
  logic hs_lead, vs_lead;

  logic [11:0] hcnt_q, hcnt_d, hsa_q, hsa_d, hde_q, hde_d;
  logic [11:0] h_total_q, h_total_d, h_sync_q, h_sync_d, h_active_q, h_active_d;
  logic [11:0] lines_q, lines_d, vsl_q, vsl_d, del_q, del_d;
  logic [11:0] hcnt_inc, hsa_inc, hde_inc, lin_inc, vsl_inc, del_inc;
  logic        hcnt_ov, hsa_ov, hde_ov, lin_ov, vsl_ov, del_ov;
  logic        ovf_q, ovf_d, ovf_now;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic        timeout_hit;
  geom_t       cand, prev_q, prev_d, meas_q, meas_d;
  state_t      state_q, state_d;
  logic [3:0]  match_q, match_d, miss_q, miss_d;
  logic        fmt_q, fmt_d, fs_q;
  logic        line_de_q, line_de_d, frame_de_q, frame_de_d, frame_de_eff, first_de;
  logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;

  assign hs_lead = hs_s1_q & ~hs_s2_q;
  assign vs_lead = vs_s1_q & ~vs_s2_q;

  assign {hcnt_ov, hcnt_inc} = sat_inc(hcnt_q, 1'b1);
  assign {hsa_ov, hsa_inc}   = sat_inc(hsa_q, hs_s1_q);
  assign {hde_ov, hde_inc}   = sat_inc(hde_q, de_s1_q);
  assign {lin_ov, lin_inc}   = sat_inc(lines_q, hs_lead);
  assign {vsl_ov, vsl_inc}   = sat_inc(vsl_q, hs_lead & vs_s1_q);
  assign {del_ov, del_inc}   = sat_inc(del_q, hs_lead & (hde_q != 12'd0));

  // The hs leading-edge clock opens the new line, so it seeds the accumulators.
  always_comb begin
    hcnt_d     = hs_lead ? 12'd0 : hcnt_inc;
    hsa_d      = hs_lead ? {11'd0, hs_s1_q} : hsa_inc;
    hde_d      = hs_lead ? {11'd0, de_s1_q} : hde_inc;
    h_total_d  = h_total_q;
    h_sync_d   = h_sync_q;
    h_active_d = h_active_q;
    if (hs_lead) begin
      h_total_d = hcnt_q;
      h_sync_d  = hsa_q;
      if (hde_q != 12'd0) h_active_d = hde_q;
    end
    ovf_now = ovf_q | ((hcnt_ov | hsa_ov | hde_ov) & ~hs_lead) | lin_ov | vsl_ov | del_ov;

    // Line-level captures use the _d values so a coincident hs edge lands in the closing frame.
    cand.h_total  = h_total_d;
    cand.h_sync   = h_sync_d;
    cand.h_active = h_active_d;
    cand.v_total  = lin_inc - 12'd1;
    cand.v_sync   = vsl_inc;
    cand.v_active = del_inc;

    lines_d = vs_lead ? 12'd0 : lin_inc;
    vsl_d   = vs_lead ? 12'd0 : vsl_inc;
    del_d   = vs_lead ? 12'd0 : del_inc;
    ovf_d   = vs_lead ? 1'b0 : ovf_now;

    tcnt_d      = hs_lead ? '0 : ((tcnt_q == TO_LAST) ? tcnt_q : tcnt_q + TW'(1));
    timeout_hit = ~hs_lead & (tcnt_q == TO_LAST);
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    prev_d  = prev_q;
    meas_d  = meas_q;
    fmt_d   = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (vs_lead) begin
          state_d = ST_MEASURE;
          match_d = 4'd0;
        end
      end
      ST_MEASURE: begin
        if (vs_lead) begin
          match_d = (cand == prev_q && !ovf_now) ? match_q + 4'd1 : 4'd1;
          prev_d  = cand;
          if (match_d == 4'(LOCK_FRAMES)) begin
            state_d = ST_LOCKED;
            meas_d  = cand;
            miss_d  = 4'd0;
            fmt_d   = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (vs_lead) begin
          miss_d = (cand == meas_q && !ovf_now) ? 4'd0 : miss_q + 4'd1;
          if (miss_d == 4'(UNLOCK_FRAMES)) begin
            state_d = ST_SEARCH;
            fmt_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase
    if (timeout_hit) begin
      state_d = ST_SEARCH;
      match_d = 4'd0;
      miss_d  = 4'd0;
      meas_d  = meas_q;
      fmt_d   = (state_q == ST_LOCKED);
    end
  end

  always_comb begin
    first_de     = de_s1_q & (hs_lead | ~line_de_q);
    line_de_d    = hs_lead ? de_s1_q : (line_de_q | de_s1_q);
    frame_de_eff = vs_lead ? 1'b0 : frame_de_q;
    frame_de_d   = frame_de_eff | de_s1_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    if (de_s1_q) pix_x_d = first_de ? 12'd0 : pix_x_q + 12'd1;
    if (first_de) pix_y_d = frame_de_eff ? pix_y_q + 12'd1 : 12'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      de_s1_q    <= 1'b0;
      hs_s2_q    <= 1'b0;
      vs_s2_q    <= 1'b0;
      hcnt_q     <= '0;
      hsa_q      <= '0;
      hde_q      <= '0;
      h_total_q  <= '0;
      h_sync_q   <= '0;
      h_active_q <= '0;
      lines_q    <= '0;
      vsl_q      <= '0;
      del_q      <= '0;
      ovf_q      <= 1'b0;
      tcnt_q     <= '0;
      state_q    <= ST_SEARCH;
      match_q    <= '0;
      miss_q     <= '0;
      prev_q     <= '0;
      meas_q     <= '0;
      fmt_q      <= 1'b0;
      fs_q       <= 1'b0;
      line_de_q  <= 1'b0;
      frame_de_q <= 1'b0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
    end else begin
      hs_s1_q    <= hdmi_hs ^ POL;
      vs_s1_q    <= hdmi_vs ^ POL;
      de_s1_q    <= hdmi_de;
      hs_s2_q    <= hs_s1_q;
      vs_s2_q    <= vs_s1_q;
      hcnt_q     <= hcnt_d;
      hsa_q      <= hsa_d;
      hde_q      <= hde_d;
      h_total_q  <= h_total_d;
      h_sync_q   <= h_sync_d;
      h_active_q <= h_active_d;
      lines_q    <= lines_d;
      vsl_q      <= vsl_d;
      del_q      <= del_d;
      ovf_q      <= ovf_d;
      tcnt_q     <= tcnt_d;
      state_q    <= state_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      prev_q     <= prev_d;
      meas_q     <= meas_d;
      fmt_q      <= fmt_d;
      fs_q       <= vs_lead;
      line_de_q  <= line_de_d;
      frame_de_q <= frame_de_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
    end
  end

  assign locked        = (state_q == ST_LOCKED);
  assign frame_start   = fs_q;
  assign fmt_change    = fmt_q;
  assign meas_h_total  = meas_q.h_total;
  assign meas_h_sync   = meas_q.h_sync;
  assign meas_h_active = meas_q.h_active;
  assign meas_v_total  = meas_q.v_total;
  assign meas_v_sync   = meas_q.v_sync;
  assign meas_v_active = meas_q.v_active;
  assign pix_x         = pix_x_q;
  assign pix_y         = pix_y_q;
endmodule

// File: tb/tb_video_timing_detector.sv
// tb/tb_video_timing_detector.sv - bench for video_timing_detector
// A raster generator drives the pins; expectations come from the generator's programmed geometry.
module tb_video_timing_detector;
  localparam int LOCK_FRAMES   = 3;
  localparam int UNLOCK_FRAMES = 2;
  localparam int TIMEOUT       = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hdmi_hs = 1'b1, hdmi_vs = 1'b1, hdmi_de = 1'b0;
  logic locked, frame_start, fmt_change;
  logic [11:0] meas_h_total, meas_h_sync, meas_h_active, meas_v_total, meas_v_sync, meas_v_active;
  logic [11:0] pix_x, pix_y;
  logic [71:0] meas_vec;

  always #5 clk = ~clk;

  video_timing_detector #(
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LOCK_FRAMES), .UNLOCK_FRAMES(UNLOCK_FRAMES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de),
    .locked(locked), .frame_start(frame_start), .fmt_change(fmt_change),
    .meas_h_total(meas_h_total), .meas_h_sync(meas_h_sync), .meas_h_active(meas_h_active),
    .meas_v_total(meas_v_total), .meas_v_sync(meas_v_sync), .meas_v_active(meas_v_active),
    .pix_x(pix_x), .pix_y(pix_y)
  );

  assign meas_vec = {meas_h_total, meas_h_sync, meas_h_active, meas_v_total, meas_v_sync, meas_v_active};

  int tests = 0, fails = 0;
  int g_ht, g_hs, g_hb, g_he, g_vt, g_vs, g_vb, g_ve;
  int hc = 0, vc = 0;
  bit kill = 1'b1;
  int cyc = 0;
  int vs_edge_cyc[$];
  int last_hs_lead_cyc = -1;
  bit prev_hs_a = 1'b0, prev_vs_a = 1'b0;
  int fmt_cnt = 0, fs_cnt = 0, lock_rise_cyc = -1, lock_fall_cyc = -1;
  bit locked_prev = 1'b0;
  bit pix_en = 1'b0;
  int pix_err = 0, pix_x_max = 0, pix_y_max = 0, bad_x = 0, bad_y = 0, bad_ex = 0, bad_ey = 0;
  bit d1_de = 1'b0, d2_de = 1'b0;
  int d1_x = 0, d1_y = 0, d2_x = 0, d2_y = 0;

  function automatic logic [71:0] exp_meas();
    return {12'(g_ht), 12'(g_hs + 1), 12'(g_he - g_hb), 12'(g_vt), 12'(g_vs + 1), 12'(g_ve - g_vb)};
  endfunction

  function automatic int frame_clks();
    return (g_ht + 1) * (g_vt + 1);
  endfunction

  task automatic set_cfg(input int ht, hs, hb, he, vt, vs, vb, ve);
    g_ht = ht; g_hs = hs; g_hb = hb; g_he = he;
    g_vt = vt; g_vs = vs; g_vb = vb; g_ve = ve;
  endtask

  task automatic random_cfg();
    int ht, hs, hb, vt, vs, vb;
    ht = $urandom_range(50, 30);
    hs = $urandom_range(5, 1);
    hb = hs + $urandom_range(5, 1);
    vt = $urandom_range(20, 12);
    vs = $urandom_range(3, 1);
    vb = vs + $urandom_range(3, 1);
    set_cfg(ht, hs, hb, $urandom_range(ht - 1, hb + 4), vt, vs, vb, $urandom_range(vt - 1, vb + 2));
  endtask

  // Start just past both sync pulses so the first vs edge seen is a genuine frame start.
  task automatic start_gen();
    hc = g_hs;
    vc = g_vs;
    vs_edge_cyc.delete();
    lock_rise_cyc = -1;
    fmt_cnt = 0;
    kill = 1'b0;
  endtask

  task automatic step();
    bit hs_a, vs_a, de_a;
    @(posedge clk);
    #1;
    cyc++;
    if (fmt_change) fmt_cnt++;
    if (frame_start) fs_cnt++;
    if (locked && !locked_prev) lock_rise_cyc = cyc;
    if (!locked && locked_prev) lock_fall_cyc = cyc;
    locked_prev = locked;
    if (pix_en && d2_de) begin
      if (int'(pix_x) > pix_x_max) pix_x_max = int'(pix_x);
      if (int'(pix_y) > pix_y_max) pix_y_max = int'(pix_y);
      if (pix_x !== 12'(d2_x) || pix_y !== 12'(d2_y)) begin
        if (pix_err == 0) begin
          bad_x = int'(pix_x); bad_y = int'(pix_y); bad_ex = d2_x; bad_ey = d2_y;
        end
        pix_err++;
      end
    end
    d2_de = d1_de; d2_x = d1_x; d2_y = d1_y;
    if (kill) begin
      hs_a = 1'b0; vs_a = 1'b0; de_a = 1'b0;
    end else begin
      hs_a = (hc == g_ht) || (hc < g_hs);
      vs_a = (vc == g_vt) || (vc < g_vs);
      de_a = (hc >= g_hb) && (hc < g_he) && (vc >= g_vb) && (vc < g_ve);
    end
    hdmi_hs = ~hs_a;
    hdmi_vs = ~vs_a;
    hdmi_de = de_a;
    if (hs_a && !prev_hs_a) last_hs_lead_cyc = cyc;
    if (vs_a && !prev_vs_a) vs_edge_cyc.push_back(cyc);
    prev_hs_a = hs_a;
    prev_vs_a = vs_a;
    d1_de = de_a; d1_x = hc - g_hb; d1_y = vc - g_vb;
    if (!kill) begin
      if (hc == g_ht) begin
        hc = 0;
        vc = (vc == g_vt) ? 0 : vc + 1;
      end else begin
        hc++;
      end
    end
  endtask

  task automatic run_until_lock(input int max_c);
    int n = 0;
    while (!locked && n < max_c) begin step(); n++; end
  endtask

  task automatic wait_frame_boundary();
    int n = 0;
    while (!(hc == 0 && vc == 0) && n < 20000) begin step(); n++; end
  endtask

  function automatic int lock_latency(input int idx, input int at);
    if (vs_edge_cyc.size() <= idx || at < 0) return -1;
    return at - vs_edge_cyc[idx];
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    kill = 1'b1;
    repeat (4) step();
    tests++;
    if ({locked, frame_start, fmt_change} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b expected 000", {locked, frame_start, fmt_change});
    end
    tests++;
    if (meas_vec !== 72'd0) begin
      fails++; $display("FAIL reset_meas: got %h expected 0", meas_vec);
    end
    tests++;
    if ({pix_x, pix_y} !== 24'd0) begin
      fails++; $display("FAIL reset_pix: got %h expected 0", {pix_x, pix_y});
    end
  endtask

  task automatic test_lock_spec();
    int lat;
    set_cfg(99, 9, 19, 89, 49, 4, 9, 45);
    start_gen();
    reset_n = 1'b1;
    run_until_lock(6 * frame_clks());
    lat = lock_latency(LOCK_FRAMES, lock_rise_cyc);
    tests++;
    if (locked !== 1'b1) begin
      fails++; $display("FAIL spec_locked: got %b expected 1", locked);
    end
    tests++;
    if (lat != 2) begin
      fails++; $display("FAIL spec_lock_edge: got latency %0d after vs edge %0d expected 2", lat, LOCK_FRAMES + 1);
    end
    tests++;
    if (meas_vec !== exp_meas()) begin
      fails++; $display("FAIL spec_meas: got %h expected %h", meas_vec, exp_meas());
    end
    tests++;
    if (fmt_cnt != 1) begin
      fails++; $display("FAIL spec_fmt_change: got %0d pulses expected 1", fmt_cnt);
    end
  endtask

  task automatic test_pix();
    pix_err = 0; pix_x_max = 0; pix_y_max = 0; fs_cnt = 0;
    pix_en = 1'b1;
    repeat (5000) step();
    pix_en = 1'b0;
    tests++;
    if (pix_err != 0) begin
      fails++; $display("FAIL pix_coord: %0d bad, first got (%0d,%0d) expected (%0d,%0d)",
                        pix_err, bad_x, bad_y, bad_ex, bad_ey);
    end
    tests++;
    if (pix_x_max != 69) begin
      fails++; $display("FAIL pix_x_max: got %0d expected 69", pix_x_max);
    end
    tests++;
    if (pix_y_max != 35) begin
      fails++; $display("FAIL pix_y_max: got %0d expected 35", pix_y_max);
    end
    tests++;
    if (fs_cnt != 1) begin
      fails++; $display("FAIL frame_start_rate: got %0d pulses in 5000 clk expected 1", fs_cnt);
    end
    tests++;
    if (fmt_cnt != 1) begin
      fails++; $display("FAIL fmt_change_stable: got %0d pulses expected 1", fmt_cnt);
    end
  endtask

  task automatic test_glitch();
    wait_frame_boundary();
    lock_fall_cyc = -1;
    g_he = 79;
    repeat (frame_clks()) step();
    g_he = 89;
    repeat (2 * frame_clks()) step();
    tests++;
    if (lock_fall_cyc != -1 || locked !== 1'b1) begin
      fails++; $display("FAIL glitch_lock_held: got fall at %0d locked=%b expected no fall", lock_fall_cyc, locked);
    end
    tests++;
    if (meas_h_active !== 12'd70) begin
      fails++; $display("FAIL glitch_h_active: got %0d expected 70", meas_h_active);
    end
  endtask

  task automatic test_reset_relock();
    int lat;
    for (int k = 0; k < 3; k++) begin
      #2;
      reset_n = 1'b0;
      #1;
      tests++;
      if ({locked, frame_start, fmt_change, meas_vec, pix_x, pix_y} !== 99'd0) begin
        fails++; $display("FAIL async_reset_%0d: got locked=%b meas=%h pix=%h expected all 0",
                          k, locked, meas_vec, {pix_x, pix_y});
      end
      kill = 1'b1;
      repeat (3) step();
      random_cfg();
      start_gen();
      reset_n = 1'b1;
      run_until_lock(8 * frame_clks());
      lat = lock_latency(LOCK_FRAMES, lock_rise_cyc);
      tests++;
      if (locked !== 1'b1 || lat != 2) begin
        fails++; $display("FAIL relock_%0d: got locked=%b latency %0d expected locked 2 clk after vs edge %0d",
                          k, locked, lat, LOCK_FRAMES + 1);
      end
      tests++;
      if (meas_vec !== exp_meas()) begin
        fails++; $display("FAIL random_meas_%0d: got %h expected %h", k, meas_vec, exp_meas());
      end
      tests++;
      if (fmt_cnt != 1) begin
        fails++; $display("FAIL random_fmt_%0d: got %0d pulses expected 1", k, fmt_cnt);
      end
    end
  endtask

  task automatic test_format_change();
    int lat, n;
    wait_frame_boundary();
    vs_edge_cyc.delete();
    lock_fall_cyc = -1;
    lock_rise_cyc = -1;
    fmt_cnt = 0;
    g_he = g_he - 3;
    n = 0;
    while (locked && n < 4 * frame_clks()) begin step(); n++; end
    lat = lock_latency(UNLOCK_FRAMES - 1, lock_fall_cyc);
    tests++;
    if (locked !== 1'b0 || lat != 2) begin
      fails++; $display("FAIL unlock_edge: got locked=%b latency %0d expected unlock 2 clk after vs edge %0d",
                        locked, lat, UNLOCK_FRAMES);
    end
    tests++;
    if (meas_vec === exp_meas()) begin
      fails++; $display("FAIL unlock_meas_retained: got %h expected old h_active %0d", meas_vec, g_he - g_hb + 3);
    end
    run_until_lock(8 * frame_clks());
    tests++;
    if (locked !== 1'b1 || meas_vec !== exp_meas()) begin
      fails++; $display("FAIL relock_new_fmt: got locked=%b meas=%h expected 1 %h", locked, meas_vec, exp_meas());
    end
    tests++;
    if (fmt_cnt != 2) begin
      fails++; $display("FAIL fmt_change_count: got %0d pulses expected 2", fmt_cnt);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    fmt_cnt = 0;
    lock_fall_cyc = -1;
    kill = 1'b1;
    while (locked && n < TIMEOUT + 100) begin step(); n++; end
    tests++;
    if (locked !== 1'b0 || lock_fall_cyc - last_hs_lead_cyc != TIMEOUT + 2) begin
      fails++; $display("FAIL timeout_unlock: got locked=%b after %0d clk expected 0 after %0d",
                        locked, lock_fall_cyc - last_hs_lead_cyc, TIMEOUT + 2);
    end
    tests++;
    if (fmt_cnt != 1) begin
      fails++; $display("FAIL timeout_fmt: got %0d pulses expected 1", fmt_cnt);
    end
    tests++;
    if (meas_vec !== exp_meas()) begin
      fails++; $display("FAIL timeout_meas_retained: got %h expected %h", meas_vec, exp_meas());
    end
  endtask

  initial begin
    test_reset();
    test_lock_spec();
    test_pix();
    test_glitch();
    test_reset_relock();
    test_format_change();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
